// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// baud divider table used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_PARITY   = 3'd4,
    ST_STOP     = 3'd5
  } tx_state_e;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    int unsigned rate;
    case (sel)
      3'b000:  rate = 32'd300;
      3'b001:  rate = 32'd1200;
      3'b010:  rate = 32'd4800;
      3'b011:  rate = 32'd9600;
      3'b100:  rate = 32'd19200;
      3'b101:  rate = 32'd38400;
      3'b110:  rate = 32'd57600;
      3'b111:  rate = 32'd115200;
      default: rate = 32'd9600;
    endcase
    return rate;
  endfunction

  // Rounded clk / (16 * baud); the half-denominator term gives round-to-nearest.
  function automatic int unsigned baud_divider(input int unsigned clk_hz,
                                               input logic [2:0] sel);
    int unsigned den;
    den = OVERSAMPLE * baud_rate(sel);
    return (clk_hz + (den / 32'd2)) / den;
  endfunction

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/baud_controller_t.sv
// Oversample tick generator: one-cycle baud_tick every divider clocks,
// restartable so a new frame begins on a full-length bit.
module baud_controller_t
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       restart,
  output logic       baud_tick
);

  localparam int unsigned MAX_DIV = baud_divider(CLK_FREQ_HZ, 3'b000);
  localparam int unsigned CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  logic [CNT_W-1:0] div_m1_s;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap_s;

  assign div_m1_s  = CNT_W'(baud_divider(CLK_FREQ_HZ, baud_select) - 32'd1);
  assign wrap_s    = (cnt_q == div_m1_s);
  assign baud_tick = wrap_s;
  assign cnt_d     = wrap_s ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit FSM: start bit, 8 data bits LSB first, even parity, stop bit,
// each bit 16 baud ticks long; TxD and Tx_BUSY are registered.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic                 Tx_EN,
  input  logic                 Tx_WR,
  input  logic [DATA_BITS-1:0] Tx_DATA,
  output logic                 TxD,
  output logic                 Tx_BUSY
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 parity_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [TICK_W-1:0]    tick_cnt_d;
  logic                 txd_q;
  logic                 busy_q;

  logic                 baud_tick_s;
  logic                 accept_s;
  logic                 bit_end_s;
  logic                 last_data_s;

  assign accept_s    = (state_q == ST_IDLE) && Tx_EN && Tx_WR;
  assign bit_end_s   = baud_tick_s && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));
  assign last_data_s = (bit_cnt_q == BIT_W'(DATA_BITS - 1));
  assign tick_cnt_d  = tick_cnt_q + TICK_W'(1);
  assign shift_d     = {1'b0, shift_q[DATA_BITS-1:1]};

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

  baud_controller_t #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_baud (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .restart     (accept_s),
    .baud_tick   (baud_tick_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_DISABLED;
      shift_q    <= {DATA_BITS{1'b0}};
      parity_q   <= 1'b0;
      bit_cnt_q  <= {BIT_W{1'b0}};
      tick_cnt_q <= {TICK_W{1'b0}};
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // Tick counter only advances on baud ticks while a frame is in flight.
      if (busy_q && baud_tick_s) begin
        tick_cnt_q <= bit_end_s ? {TICK_W{1'b0}} : tick_cnt_d;
      end

      case (state_q)
        ST_DISABLED: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          if (Tx_EN) begin
            state_q <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          if (!Tx_EN) begin
            state_q <= ST_DISABLED;
          end else if (Tx_WR) begin
            shift_q    <= Tx_DATA;
            parity_q   <= even_parity(Tx_DATA);
            bit_cnt_q  <= {BIT_W{1'b0}};
            tick_cnt_q <= {TICK_W{1'b0}};
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end_s) begin
            txd_q   <= shift_q[0];
            state_q <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_end_s) begin
            shift_q <= shift_d;
            if (last_data_s) begin
              txd_q   <= parity_q;
              state_q <= ST_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              txd_q     <= shift_q[1];
            end
          end
        end

        ST_PARITY: begin
          if (bit_end_s) begin
            txd_q   <= 1'b1;
            state_q <= ST_STOP;
          end
        end

        // Busy drops as STOP ends so a write on the very next cycle is accepted.
        ST_STOP: begin
          if (bit_end_s) begin
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
            state_q <= Tx_EN ? ST_IDLE : ST_DISABLED;
          end
        end

        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_DISABLED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench: captures TxD every cycle of each frame and compares it
// against a frame model built from the byte value and the bit length.
module tb_uart_transmitter;

  localparam int BIT_CYC   = 16 * 54;
  localparam int FRAME_CYC = 11 * BIT_CYC;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       TxD;
  logic       Tx_BUSY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  logic line_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_transmitter #(
    .CLK_FREQ_HZ (100_000_000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Line value of frame bit k: start, data LSB first, even parity, stop.
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return ((d >> (k - 1)) & 8'd1) != 8'd0;
    if (k == 9) return ($countones(d) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic idle_watch(input string tag, input int ncyc);
    int good;
    good = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (TxD === 1'b1 && Tx_BUSY === 1'b0) good++;
    end
    chk(tag, good, ncyc);
  endtask

  // Called at a negedge; returns at the negedge where Tx_BUSY is first low.
  task automatic run_frame(input logic [7:0] d, input string name, input bit b2b,
                           input int wr_at, input int drop_at, input int rst_at);
    int n;
    int good;
    int first_cyc;
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Tx_WR = 1'b0;
    first_cyc = cyc;
    if (b2b) chk({name, " b2b_gap"}, first_cyc - fall_cyc, 1);
    line_q.delete();
    n = 0;
    while (Tx_BUSY === 1'b1 && n < FRAME_CYC + 100) begin
      line_q.push_back(TxD);
      if (n == wr_at) begin
        Tx_DATA = 8'hFF;
        Tx_WR   = 1'b1;
      end else begin
        Tx_WR = 1'b0;
      end
      if (n == drop_at) Tx_EN = 1'b0;
      if (n == rst_at) begin
        chk({name, " parity_before_rst"}, TxD, exp_bit(d, 9));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk({name, " rst_TxD"}, TxD, 1'b1);
        chk({name, " rst_busy"}, Tx_BUSY, 1'b0);
        return;
      end
      n++;
      @(negedge clk);
    end
    Tx_WR = 1'b0;
    fall_cyc = cyc;
    chk({name, " busy_cycles"}, n, FRAME_CYC);
    chk({name, " idle_after"}, TxD, 1'b1);
    for (int k = 0; k < 11; k++) begin
      good = 0;
      for (int i = k * BIT_CYC; i < (k + 1) * BIT_CYC; i++) begin
        if (i < line_q.size() && line_q[i] === exp_bit(d, k)) good++;
      end
      chk($sformatf("%s bit%0d", name, k), good, BIT_CYC);
    end
  endtask

  initial begin
    logic [7:0] rnd;
    reset       = 1'b1;
    baud_select = 3'b111;
    Tx_EN       = 1'b0;
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset TxD", TxD, 1'b1);
    chk("reset busy", Tx_BUSY, 1'b0);

    // Write while disabled is dropped.
    Tx_DATA = 8'hA5;
    Tx_WR   = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    idle_watch("disabled_write", 40);

    // Write in the same cycle enable rises is dropped.
    Tx_EN = 1'b1;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    idle_watch("enable_same_cycle_write", 40);

    run_frame(8'hA5, "A5", 1'b0, -1, -1, -1);
    idle_watch("gap1", 5);
    run_frame(8'h07, "07", 1'b0, -1, -1, -1);
    idle_watch("gap2", 5);
    run_frame(8'h00, "00", 1'b0, -1, -1, -1);
    idle_watch("gap3", 5);
    run_frame(8'h3C, "3C", 1'b0, 5 * BIT_CYC + 100, -1, -1);
    run_frame(8'h81, "81", 1'b1, -1, -1, -1);
    idle_watch("gap4", 5);

    run_frame(8'h55, "55", 1'b0, -1, 4 * BIT_CYC + int'($urandom_range(0, BIT_CYC - 1)), -1);
    idle_watch("after_drop", 5);
    Tx_DATA = 8'h5A;
    Tx_WR   = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    idle_watch("write_after_drop", 40);

    Tx_EN = 1'b1;
    repeat (2) @(negedge clk);
    rnd = 8'($urandom);
    run_frame(rnd, "rand_rst", 1'b0, -1, -1, 9 * BIT_CYC + int'($urandom_range(0, BIT_CYC - 1)));
    idle_watch("after_reset", 3);
    run_frame(8'h12, "12", 1'b0, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
